// File: rtl/sh7604_ext_resp_pkg.sv
// Shared types and constants for the SH7604 external-bus responder.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, byte-lane geometry (lane 3 = MSB) and the
// wait-state counter width.
package sh7604_ext_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Byte lanes of the 32-bit data bus; lane 3 carries DO[31:24].
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int LANE_MSB  = 3;
  localparam int LANE_LSB  = 0;

  // Wait-state counter: 4 bits, so at most 15 wait ticks per access.
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // Bus write enables are active low; the RAM wants active-high lane strobes.
  function automatic logic [NUM_LANES-1:0] lane_enables(input logic [NUM_LANES-1:0] we_n);
    return ~we_n;
  endfunction

endpackage

// File: rtl/sh7604_resp_ram.sv
// Single-port 2^ADDR_W x 32 RAM with per-byte write strobes and registered read.
// Latency: read data appears on rdata one CLK edge after rd_en; writes land on the same edge.
// Backpressure: none; the caller gates rd_en/we with its own clock enable.
//
// Ports:
//   CLK    clock
//   addr   word index
//   rd_en  load rdata from mem[addr]; rdata holds otherwise
//   we     active-high byte strobes, we[3] -> wdata[31:24]
//   wdata  write data
//   rdata  registered read data
module sh7604_resp_ram
  import sh7604_ext_resp_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic                 CLK,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 rd_en,
  input  logic [NUM_LANES-1:0] we,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Power-up content only; reset never touches the array.
  localparam logic [31:0] INIT_WORD = (INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx;

  logic [31:0] mem [DEPTH] = '{default: INIT_WORD};

  always_ff @(posedge CLK) begin
    for (int i = LANE_LSB; i <= LANE_MSB; i++) begin
      if (we[i]) begin
        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
    // rdata only moves on an explicit read so it can be held across HOLD.
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sh7604_ext_resp.sv
// SH7604 external-bus responder for one chip-select area, backed by a 32-bit RAM.
// Latency: read data valid WAIT_STATES+1 CE_R ticks after the start tick.
// Backpressure: WAIT_N held low for WAIT_STATES ticks per access; CE_R=0 freezes all state.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   CE_R             clock enable for every state change except reset
//   A, DO            CPU address / write data
//   BS_N, CS_N       bus-start strobe and area select (active low)
//   RD_WR_N, RD_N    direction (1=read) and read qualifier (active low)
//   WE_N             active-low byte write enables, WE_N[3] -> DO[31:24]
//   DI, DI_OE        read data and its valid flag
//   WAIT_N           wait request to CPU (active low)
//   BUSY             high whenever the FSM is not idle
module sh7604_ext_resp
  import sh7604_ext_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2,
  parameter int INIT_ZERO   = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DO,
  input  logic        BS_N,
  input  logic        CS_N,
  input  logic        RD_WR_N,
  input  logic        RD_N,
  input  logic [3:0]  WE_N,
  output logic [31:0] DI,
  output logic        DI_OE,
  output logic        WAIT_N,
  output logic        BUSY
);

  // Anything above the counter range saturates rather than wrapping to a short wait.
  localparam int              WS_EFF   = (WAIT_STATES > CNT_MAX) ? CNT_MAX : WAIT_STATES;
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WS_EFF);
  localparam bit              HAS_WAIT = (WS_EFF > 0);

  state_e              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic                rd_wr_n_q;
  logic [3:0]          we_n_q;
  logic                di_oe_q;

  logic                start;
  logic                accept;
  logic                data_tick;
  logic                ram_rd_en;
  logic [NUM_LANES-1:0] ram_we;
  logic [31:0]         ram_rdata;
  logic                unused_addr;

  // A start is only honoured from IDLE or HOLD (back-to-back); BS_N with CS_N=1 is ignored.
  assign start  = ~BS_N & ~CS_N;
  assign accept = CE_R & start & ((state == ST_IDLE) | (state == ST_HOLD));

  // The DATA tick is the single tick on which the RAM is touched. Masking with
  // RST drops a write that would otherwise land on the reset edge.
  assign data_tick = CE_R & ~RST & (state == ST_DATA);
  assign ram_rd_en = data_tick & rd_wr_n_q;
  assign ram_we    = {NUM_LANES{data_tick & ~rd_wr_n_q}} & lane_enables(we_n_q);

  // Word index aliases: address bits above the RAM depth and the byte offset are dropped.
  assign unused_addr = ^{A[26:ADDR_W+2], A[1:0]};

  // Access attributes captured at the start tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_idx  <= '0;
      rd_wr_n_q <= 1'b1;
      we_n_q    <= 4'hF;
    end else if (accept) begin
      word_idx  <= A[ADDR_W+1:2];
      rd_wr_n_q <= RD_WR_N;
      we_n_q    <= WE_N;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      di_oe_q  <= 1'b0;
    end else if (CE_R) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            wait_cnt <= WS_LOAD;
            state    <= HAS_WAIT ? ST_WAIT : ST_DATA;
          end
        end

        ST_WAIT: begin
          if (CS_N) begin
            // CPU abandoned the cycle: nothing has been written yet.
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else if (wait_cnt <= CNT_W'(1)) begin
            wait_cnt <= '0;
            state    <= ST_DATA;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        ST_DATA: begin
          // RD_N only qualifies the output enable; the FSM advances either way.
          di_oe_q <= rd_wr_n_q & ~RD_N;
          state   <= ST_HOLD;
        end

        ST_HOLD: begin
          if (start) begin
            di_oe_q  <= 1'b0;
            wait_cnt <= WS_LOAD;
            state    <= HAS_WAIT ? ST_WAIT : ST_DATA;
          end else if (CS_N) begin
            di_oe_q <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: begin
          di_oe_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  sh7604_resp_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .CLK   (CLK),
    .addr  (word_idx),
    .rd_en (ram_rd_en),
    .we    (ram_we),
    .wdata (DO),
    .rdata (ram_rdata)
  );

  // The RAM output register is not reset, so DI is forced to zero whenever it is not valid.
  assign DI     = di_oe_q ? ram_rdata : 32'h0000_0000;
  assign DI_OE  = di_oe_q;
  assign WAIT_N = (state != ST_WAIT);
  assign BUSY   = (state != ST_IDLE);

endmodule

// File: tb/tb_sh7604_ext_resp.sv
module tb_sh7604_ext_resp;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE_R;
  logic [26:0] A;
  logic [31:0] DO;
  logic        BS_N, CS_N, RD_WR_N, RD_N;
  logic [3:0]  WE_N;

  logic [31:0] di_2, di_0;
  logic        di_oe_2, di_oe_0, wait_n_2, wait_n_0, busy_2, busy_0;

  int total = 0;
  int bad   = 0;

  int          w2, l2, w0, l0;
  logic [31:0] d2, d0;
  logic        be;

  always #5 CLK = ~CLK;

  sh7604_ext_resp #(.ADDR_W(10), .WAIT_STATES(2), .INIT_ZERO(1)) u_dut2 (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .A(A), .DO(DO), .BS_N(BS_N), .CS_N(CS_N),
    .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N),
    .DI(di_2), .DI_OE(di_oe_2), .WAIT_N(wait_n_2), .BUSY(busy_2)
  );

  sh7604_ext_resp #(.ADDR_W(10), .WAIT_STATES(0), .INIT_ZERO(1)) u_dut0 (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .A(A), .DO(DO), .BS_N(BS_N), .CS_N(CS_N),
    .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N),
    .DI(di_0), .DI_OE(di_oe_0), .WAIT_N(wait_n_0), .BUSY(busy_0)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    BS_N = 1'b1; CS_N = 1'b1; RD_N = 1'b1; RD_WR_N = 1'b1; WE_N = 4'hF;
  endtask

  // One bus cycle with CS_N held low for a 7-tick window, then released.
  // Sample k is taken 1 time unit after the k-th edge following the start edge (k=0).
  task automatic access(input logic rw, input logic rdn, input logic [26:0] a,
                        input logic [3:0] wen, input logic [31:0] d,
                        output int wlo2, output int lat2, output logic [31:0] rd2,
                        output int wlo0, output int lat0, output logic [31:0] rd0,
                        output logic busy_end);
    wlo2 = 0; lat2 = -1; wlo0 = 0; lat0 = -1;
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = rw; RD_N = rdn; A = a; WE_N = wen; DO = d;
    for (int k = 0; k < 7; k++) begin
      tick();
      BS_N = 1'b1;
      if (!wait_n_2) wlo2++;
      if (!wait_n_0) wlo0++;
      if (di_oe_2 && lat2 < 0) lat2 = k;
      if (di_oe_0 && lat0 < 0) lat0 = k;
    end
    rd2 = di_2;
    rd0 = di_0;
    idle_bus();
    tick();
    busy_end = busy_2 | busy_0;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE_R = 1'b1; A = '0; DO = '0;
    idle_bus();
    tick(); tick();
    total++;
    if ({wait_n_2, di_oe_2, busy_2, di_2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_ws2 got wait_n=%b di_oe=%b busy=%b di=%h want 1 0 0 00000000",
               wait_n_2, di_oe_2, busy_2, di_2);
    end
    total++;
    if ({wait_n_0, di_oe_0, busy_0, di_0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_ws0 got wait_n=%b di_oe=%b busy=%b di=%h want 1 0 0 00000000",
               wait_n_0, di_oe_0, busy_0, di_0);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    access(1'b0, 1'b1, 27'h10, 4'b0000, 32'hDEADBEEF, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (w2 !== 2) begin bad++; $display("FAIL wr_wait_lo got %0d want 2", w2); end
    total++;
    if (l2 !== -1) begin bad++; $display("FAIL wr_no_di_oe got first_oe=%0d want -1", l2); end
    total++;
    if (be !== 1'b0) begin bad++; $display("FAIL wr_idle_after got busy=%b want 0", be); end
    // WE_N all enabled and DO=0 on a read: must not disturb the word.
    access(1'b1, 1'b0, 27'h10, 4'b0000, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (w2 !== 2) begin bad++; $display("FAIL rd_wait_lo got %0d want 2", w2); end
    total++;
    if (l2 !== 3) begin bad++; $display("FAIL rd_latency got %0d want 3", l2); end
    total++;
    if (d2 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got %h want deadbeef", d2); end
  endtask

  task automatic test_zero_wait();
    access(1'b1, 1'b0, 27'h10, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (w0 !== 0) begin bad++; $display("FAIL ws0_wait_lo got %0d want 0", w0); end
    total++;
    if (l0 !== 1) begin bad++; $display("FAIL ws0_latency got %0d want 1", l0); end
    total++;
    if (d0 !== 32'hDEADBEEF) begin bad++; $display("FAIL ws0_data got %h want deadbeef", d0); end
    total++;
    if (d2 !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_ignores_we got %h want deadbeef", d2); end
  endtask

  task automatic test_byte_lanes();
    access(1'b0, 1'b1, 27'h20, 4'b0000, 32'h11223344, w2, l2, d2, w0, l0, d0, be);
    access(1'b0, 1'b1, 27'h20, 4'b1010, 32'hAABBCCDD, w2, l2, d2, w0, l0, d0, be);
    access(1'b1, 1'b0, 27'h20, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h11BB33DD) begin bad++; $display("FAIL lanes_1010 got %h want 11bb33dd", d2); end
    total++;
    if (d0 !== 32'h11BB33DD) begin bad++; $display("FAIL lanes_1010_ws0 got %h want 11bb33dd", d0); end
    access(1'b0, 1'b1, 27'h20, 4'b1111, 32'h99999999, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (w2 !== 2 || be !== 1'b0) begin
      bad++; $display("FAIL lanes_none_cycle got wait_lo=%0d busy=%b want 2 0", w2, be);
    end
    access(1'b0, 1'b1, 27'h20, 4'b0111, 32'h77000000, w2, l2, d2, w0, l0, d0, be);
    access(1'b1, 1'b0, 27'h20, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h77BB33DD) begin bad++; $display("FAIL lanes_msb_only got %h want 77bb33dd", d2); end
  endtask

  task automatic test_abort();
    access(1'b0, 1'b1, 27'h40, 4'b0000, 32'h12345678, w2, l2, d2, w0, l0, d0, be);
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h40; WE_N = 4'b0000; DO = 32'hFFFFFFFF;
    tick();
    BS_N = 1'b1;
    total++;
    if (wait_n_2 !== 1'b0) begin bad++; $display("FAIL abort_in_wait got wait_n=%b want 0", wait_n_2); end
    CS_N = 1'b1;
    tick();
    total++;
    if ({wait_n_2, busy_2, di_oe_2} !== 3'b100) begin
      bad++; $display("FAIL abort_exit got wait_n=%b busy=%b di_oe=%b want 1 0 0", wait_n_2, busy_2, di_oe_2);
    end
    idle_bus();
    tick();
    access(1'b1, 1'b0, 27'h40, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h12345678) begin bad++; $display("FAIL abort_no_write got %h want 12345678", d2); end
  endtask

  task automatic test_back_to_back();
    int lo;
    access(1'b0, 1'b1, 27'h04, 4'b0000, 32'h0A0A0A0A, w2, l2, d2, w0, l0, d0, be);
    access(1'b0, 1'b1, 27'h08, 4'b0000, 32'h0B0B0B0B, w2, l2, d2, w0, l0, d0, be);
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = 1'b1; RD_N = 1'b0; A = 27'h04; WE_N = 4'hF;
    tick();
    BS_N = 1'b1;
    tick(); tick(); tick();
    total++;
    if (di_oe_2 !== 1'b1 || di_2 !== 32'h0A0A0A0A) begin
      bad++; $display("FAIL b2b_first got oe=%b di=%h want 1 0a0a0a0a", di_oe_2, di_2);
    end
    BS_N = 1'b0; A = 27'h08;
    tick();
    BS_N = 1'b1;
    total++;
    if ({wait_n_2, busy_2, di_oe_2} !== 3'b010) begin
      bad++; $display("FAIL b2b_restart got wait_n=%b busy=%b oe=%b want 0 1 0", wait_n_2, busy_2, di_oe_2);
    end
    lo = wait_n_2 ? 0 : 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!wait_n_2) lo++;
    end
    total++;
    if (lo !== 2) begin bad++; $display("FAIL b2b_wait_lo got %0d want 2", lo); end
    total++;
    if (di_oe_2 !== 1'b1 || di_2 !== 32'h0B0B0B0B) begin
      bad++; $display("FAIL b2b_second got oe=%b di=%h want 1 0b0b0b0b", di_oe_2, di_2);
    end
    total++;
    if (di_0 !== 32'h0B0B0B0B) begin bad++; $display("FAIL b2b_second_ws0 got %h want 0b0b0b0b", di_0); end
    idle_bus();
    tick();
  endtask

  task automatic test_alias();
    access(1'b0, 1'b1, 27'h0, 4'b0000, 32'hCAFEF00D, w2, l2, d2, w0, l0, d0, be);
    access(1'b1, 1'b0, 27'h1000, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'hCAFEF00D) begin bad++; $display("FAIL alias_1000 got %h want cafef00d", d2); end
    access(1'b0, 1'b1, 27'h4000008, 4'b0000, 32'h5A5A5A5A, w2, l2, d2, w0, l0, d0, be);
    access(1'b1, 1'b0, 27'h08, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h5A5A5A5A) begin bad++; $display("FAIL alias_high got %h want 5a5a5a5a", d2); end
  endtask

  task automatic test_ce_stall();
    int lo;
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = 1'b1; RD_N = 1'b0; A = 27'h20; WE_N = 4'hF;
    tick();
    BS_N = 1'b1;
    CE_R = 1'b0;
    lo = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (!wait_n_2 && !di_oe_2) lo++;
    end
    total++;
    if (lo !== 3) begin bad++; $display("FAIL ce_stall_hold got %0d want 3", lo); end
    CE_R = 1'b1;
    tick();
    total++;
    if (wait_n_2 !== 1'b0) begin bad++; $display("FAIL ce_resume_wait got wait_n=%b want 0", wait_n_2); end
    tick(); tick();
    total++;
    if (di_oe_2 !== 1'b1 || di_2 !== 32'h77BB33DD) begin
      bad++; $display("FAIL ce_resume_data got oe=%b di=%h want 1 77bb33dd", di_oe_2, di_2);
    end
    idle_bus();
    tick();
  endtask

  task automatic test_rd_qualifier();
    access(1'b1, 1'b1, 27'h20, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (l2 !== -1 || l0 !== -1) begin
      bad++; $display("FAIL rdn_high_oe got first_oe=%0d/%0d want -1/-1", l2, l0);
    end
    total++;
    if (w2 !== 2 || be !== 1'b0) begin
      bad++; $display("FAIL rdn_high_cycle got wait_lo=%0d busy=%b want 2 0", w2, be);
    end
  endtask

  task automatic test_rst_mid();
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h04; WE_N = 4'b0000; DO = 32'h55555555;
    tick();
    BS_N = 1'b1;
    tick();
    RST = 1'b1; CE_R = 1'b0;
    tick();
    total++;
    if ({wait_n_2, busy_2, di_oe_2} !== 3'b100) begin
      bad++; $display("FAIL rst_in_wait got wait_n=%b busy=%b oe=%b want 1 0 0", wait_n_2, busy_2, di_oe_2);
    end
    RST = 1'b0; CE_R = 1'b1;
    idle_bus();
    tick();
    access(1'b1, 1'b0, 27'h04, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h0A0A0A0A) begin bad++; $display("FAIL rst_ram_kept got %h want 0a0a0a0a", d2); end
    // Reset landing on the DATA tick must drop the write.
    BS_N = 1'b0; CS_N = 1'b0; RD_WR_N = 1'b0; A = 27'h08; WE_N = 4'b0000; DO = 32'h66666666;
    tick();
    BS_N = 1'b1;
    tick(); tick();
    RST = 1'b1;
    tick();
    total++;
    if (busy_2 !== 1'b0) begin bad++; $display("FAIL rst_in_data got busy=%b want 0", busy_2); end
    RST = 1'b0;
    idle_bus();
    tick();
    access(1'b1, 1'b0, 27'h08, 4'hF, 32'h0, w2, l2, d2, w0, l0, d0, be);
    total++;
    if (d2 !== 32'h5A5A5A5A) begin bad++; $display("FAIL rst_drops_write got %h want 5a5a5a5a", d2); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_byte_lanes();
    test_abort();
    test_back_to_back();
    test_alias();
    test_ce_stall();
    test_rd_qualifier();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
